// File: rtl/name_table_row_loader_pkg.sv
// Shared constants and FSM encoding for the name-table row loader.
// Geometry defaults are exposed here so the top, the port mux and any
// software-facing collateral agree on a single set of numbers.
package name_table_row_loader_pkg;

    localparam int NTL_RAM_AW        = 9;    // 512-word name-table RAM
    localparam int NTL_ROM_AW        = 12;   // map-ROM word address width
    localparam int NTL_ROWS          = 30;   // valid destination rows 0..29
    localparam int NTL_WORDS_PER_ROW = 8;    // 32 tiles, 4 per word
    localparam int NTL_ATTR_BASE     = 240;  // attribute region word address

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } ntl_state_t;

endpackage

// File: rtl/name_table_row_loader_port_mux.sv
// ntl_port_mux: combinational write-port priority mux for the name-table
// RAM. The CPU owns the port whenever any byte enable is set; otherwise the
// loader may write a full word; otherwise the port is quiet (all zero).
module ntl_port_mux #(
    parameter int RAM_AW = 9
) (
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [31:0]       cpu_din,
    input  logic [3:0]        cpu_we,
    input  logic              ld_req,
    input  logic [RAM_AW-1:0] ld_addr,
    input  logic [31:0]       ld_din,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [3:0]        ram_we
);

    // CPU first, loader second, idle port driven to zero
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 4'h0;
        if (cpu_we != 4'h0) begin
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
            ram_we   = cpu_we;
        end else if (ld_req) begin
            ram_addr = ld_addr;
            ram_din  = ld_din;
            ram_we   = 4'hF;
        end
    end

endmodule

// File: rtl/name_table_row_loader.sv
// name_table_row_loader: copies one background row from the level-map ROM
// into the name-table RAM, one word every three cycles, yielding the RAM
// write port to the CPU whenever the CPU writes.
// Optional attribute copy: define NTL_ATTR_COPY_EN to also copy the two
// attribute words that follow the tile words in each ROM row.
module name_table_row_loader
    import name_table_row_loader_pkg::*;
#(
    parameter int RAM_AW        = NTL_RAM_AW,
    parameter int ROM_AW        = NTL_ROM_AW,
    parameter int ROWS          = NTL_ROWS,
    parameter int WORDS_PER_ROW = NTL_WORDS_PER_ROW,
    parameter int ATTR_BASE     = NTL_ATTR_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [31:0]       cpu_din,
    input  logic [3:0]        cpu_we,
    input  logic              start,
    input  logic [7:0]        src_row,
    input  logic [4:0]        dst_row,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] map_addr,
    input  logic [31:0]       map_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [3:0]        ram_we
);

`ifdef NTL_ATTR_COPY_EN
    localparam int ATTR_WORDS = 2;
`else
    localparam int ATTR_WORDS = 0;
`endif
    // ROM row stride and number of words moved per load
    localparam int STRIDE = WORDS_PER_ROW + ATTR_WORDS;
    localparam int CW     = $clog2(STRIDE) + 1;

    ntl_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        src_q;
    logic [4:0]        dst_q;
    logic [31:0]       data_q;
    logic              cpu_active;
    logic              accept;
    logic              last;
    logic              ld_req;
    logic [RAM_AW-1:0] ld_addr;

    assign cpu_active = (cpu_we != 4'h0);
    assign accept     = start && ({27'd0, dst_row} < 32'(ROWS));
    assign last       = (cnt_q == CW'(STRIDE - 1));

    // Source word address in the map ROM, truncated to the ROM width
    function automatic logic [ROM_AW-1:0] src_word(input logic [7:0] row,
                                                   input logic [CW-1:0] idx);
        return ROM_AW'(int'(row) * STRIDE + int'(idx));
    endfunction

    // Destination address: tile words fill the row, attribute words (if any)
    // land in the attribute region, two per row
    always_comb begin
        ld_addr = RAM_AW'(int'(dst_q) * WORDS_PER_ROW + int'(cnt_q));
        if (ATTR_WORDS != 0 && int'(cnt_q) >= WORDS_PER_ROW)
            ld_addr = RAM_AW'(ATTR_BASE + int'(dst_q) * ATTR_WORDS
                              + int'(cnt_q) - WORDS_PER_ROW);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status decode; a CPU write in WRITE stalls the loader
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        ld_req  = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = FETCH;
            FETCH:   begin busy = 1'b1; state_d = CAPTURE; end
            CAPTURE: begin busy = 1'b1; state_d = WRITE; end
            WRITE: begin
                busy   = 1'b1;
                ld_req = 1'b1;
                if (!cpu_active) state_d = last ? DONE : FETCH;
            end
            DONE:    begin done = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: argument latch, word counter, ROM address and data latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            data_q   <= '0;
            map_addr <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    src_q    <= src_row;
                    dst_q    <= dst_row;
                    cnt_q    <= '0;
                    map_addr <= src_word(src_row, '0);
                end
                CAPTURE: data_q <= map_data;
                WRITE: if (!cpu_active && !last) begin
                    cnt_q    <= cnt_q + CW'(1);
                    map_addr <= src_word(src_q, cnt_q + CW'(1));
                end
                default: ;
            endcase
        end
    end

    ntl_port_mux #(.RAM_AW(RAM_AW)) u_port_mux (
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_we   (cpu_we),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_din   (data_q),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we)
    );

endmodule

// File: tb/tb_name_table_row_loader.sv
// Bench for name_table_row_loader: ROM and RAM models, a scoreboard of
// expected loader writes, a table of load scenarios and a few hand sequences.
module tb_name_table_row_loader;

`ifdef NTL_ATTR_COPY_EN
    localparam int NW = 10;
    localparam int S  = 10;
`else
    localparam int NW = 8;
    localparam int S  = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  cpu_addr = '0;
    logic [31:0] cpu_din = '0;
    logic [3:0]  cpu_we = '0;
    logic        start = 1'b0;
    logic [7:0]  src_row = '0;
    logic [4:0]  dst_row = '0;
    logic        busy, done;
    logic [11:0] map_addr;
    logic [31:0] map_data = '0;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_we;

    always #5 clk = ~clk;

    name_table_row_loader dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_we(cpu_we), .start(start), .src_row(src_row), .dst_row(dst_row),
        .busy(busy), .done(done), .map_addr(map_addr), .map_data(map_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we)
    );

    function automatic logic [31:0] rom(input logic [11:0] k);
        return 32'hA000_0000 + 32'(k) - 32'd24;
    endfunction

    function automatic logic [11:0] exp_src(input logic [7:0] s, input int i);
        return 12'(int'(s) * S + i);
    endfunction

    function automatic logic [8:0] exp_dst(input logic [4:0] d, input int i);
        if (i < 8) return 9'(int'(d) * 8 + i);
        return 9'(240 + int'(d) * 2 + i - 8);
    endfunction

    // 1-cycle latency map ROM
    always @(posedge clk) map_data <= rom(map_addr);

    // Name-table RAM model with byte enables
    logic [31:0] ram [512];
    always @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sbq[$];

    // Port monitor: CPU passthrough, loader writes against the scoreboard
    always @(negedge clk) if (!rst) begin
        if (cpu_we != 4'h0) begin
            chk("mux_cpu_addr", 32'(ram_addr), 32'(cpu_addr));
            chk("mux_cpu_din", ram_din, cpu_din);
            chk("mux_cpu_we", 32'(ram_we), 32'(cpu_we));
        end else if (ram_we != 4'h0) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", ram_addr, ram_din);
            end else begin
                wr_t e;
                e = sbq.pop_front();
                chk("ld_addr", 32'(ram_addr), 32'(e.addr));
                chk("ld_data", ram_din, e.data);
                chk("ld_we", 32'(ram_we), 32'hF);
            end
        end else begin
            chk("idle_addr", 32'(ram_addr), 32'd0);
            chk("idle_din", ram_din, 32'd0);
        end
    end

    typedef struct {
        logic [7:0] src;
        logic [4:0] dst;
        int stall;       // CPU write cycles starting at the first WRITE
        int restart_at;  // cycle of a second start pulse (0 = none)
        int rst_at;      // cycle reset is raised (0 = none)
        int n_wr;        // loader writes expected
        int exp_busy;
        int exp_done;
    } vec_t;

    task automatic run_vec(input vec_t t);
        int busy_n, done_n, done_at, win;
        busy_n = 0; done_n = 0; done_at = 0;
        for (int i = 0; i < NW; i++) ram[exp_dst(t.dst, i)] = 32'hDEAD_BEEF;
        for (int i = 0; i < t.n_wr; i++)
            sbq.push_back('{exp_dst(t.dst, i), rom(exp_src(t.src, i))});
        @(posedge clk); #1;
        start = 1'b1; src_row = t.src; dst_row = t.dst;
        win = (t.rst_at != 0) ? t.rst_at : 3 * NW + t.stall + 6;
        for (int c = 1; c <= win; c++) begin
            @(posedge clk); #1;
            start   = (c == t.restart_at);
            src_row = 8'd7;
            dst_row = 5'd9;
            if (c >= 3 && c < 3 + t.stall) begin
                cpu_we   = 4'hF;
                cpu_addr = exp_dst(t.dst, 0);
                cpu_din  = 32'hC0DE_0000 + 32'(c);
            end else begin
                cpu_we = 4'h0;
            end
            if (c == t.rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end else begin
                @(negedge clk);
                if (busy) busy_n++;
                if (done) begin done_n++; done_at = c; end
            end
        end
        if (t.rst_at != 0) begin
            @(posedge clk); #1;
            rst = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("busy_cycles", 32'(busy_n), 32'(t.exp_busy));
        chk("done_pulses", 32'(done_n), 32'(t.exp_done));
        if (t.exp_done != 0) chk("done_cycle", 32'(done_at), 32'(t.exp_busy + 1));
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        sbq.delete();
        for (int i = 0; i < NW; i++)
            chk("ram_word", ram[exp_dst(t.dst, i)],
                (i < t.n_wr) ? rom(exp_src(t.src, i)) : 32'hDEAD_BEEF);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{8'd3,   5'd5,  0, 0,  0, NW, 3*NW,     1};
        vt[1] = '{8'd3,   5'd5,  4, 0,  0, NW, 3*NW + 4, 1};
        vt[2] = '{8'd6,   5'd29, 0, 0,  0, NW, 3*NW,     1};
        vt[3] = '{8'd3,   5'd5,  0, 10, 0, NW, 3*NW,     1};
        vt[4] = '{8'd2,   5'd0,  0, 0, 12, 3,  11,       0};
        vt[5] = '{8'd1,   5'd4,  0, 0,  0, NW, 3*NW,     1};

        // Reset state
        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_map_addr", 32'(map_addr), 32'd0);
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 6; v++) run_vec(vt[v]);

        // Out-of-range destination rows are ignored
        for (int d = 30; d < 32; d++) begin
            int seen;
            seen = 0;
            @(posedge clk); #1;
            start = 1'b1; src_row = 8'd3; dst_row = 5'(d);
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (busy || done || ram_we != 4'h0) seen++;
            end
            chk("bad_row_quiet", 32'(seen), 32'd0);
        end

        // Lone CPU write while idle goes straight through
        @(posedge clk); #1;
        cpu_we = 4'h3; cpu_addr = 9'd100; cpu_din = 32'h1234_5678;
        @(posedge clk); #1;
        cpu_we = 4'h0;
        @(posedge clk); #1;
        chk("cpu_bytes", ram[100] & 32'h0000_FFFF, 32'h0000_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
